spi_master_engine: RTL and testbench

SPI_MASTER_ENGINE -- requirements
Module: spi_master_engine

---
 rtl/spi_master_engine.sv | 161 ++++++++++++++++
 tb/tb_spi_master_engine.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_engine.sv
// SPI master shift engine: single-lane (STD) and quad-lane TX/RX transfers, SPI mode 0,
// programmable SCK divider, with receive-word handshake towards the host.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_IDLE     | ready for a command, csn high, all pads quiet
// ST_CS_SETUP | csn low, first bit/nibble on sdo, waiting div+1 cycles
// ST_SHIFT    | sck toggling every div+1 cycles, sample on rise, advance on fall
// ST_CS_HOLD  | csn still low, sck low for div+1 cycles after the last fall
// ST_RX_WAIT  | received word presented on rx_data_o until rx_ready_i
module spi_master_engine #(
   parameter int DIV_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [1:0]       cmd_mode_i,
   input  logic [4:0]       cmd_len_i,
   input  logic [31:0]      cmd_txdata_i,
   input  logic [DIV_W-1:0] cmd_div_i,
   output logic             rx_valid_o,
   input  logic             rx_ready_i,
   output logic [31:0]      rx_data_o,
   output logic             busy_o,
   output logic [1:0]       padmode_o,
   output logic             spi_csn_o,
   output logic             spi_sck_o,
   output logic             spi_sdo0_o,
   output logic             spi_sdo1_o,
   output logic             spi_sdo2_o,
   output logic             spi_sdo3_o,
   input  logic             spi_sdi0_i,
   input  logic             spi_sdi1_i,
   input  logic             spi_sdi2_i,
   input  logic             spi_sdi3_i
);

   localparam logic [1:0] MODE_STD = 2'b00;
   localparam logic [1:0] MODE_QTX = 2'b01;
   localparam logic [1:0] MODE_QRX = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_SHIFT,
      ST_CS_HOLD,
      ST_RX_WAIT
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_mode;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_div_cnt;
   logic [5:0]       r_half_cnt;
   logic             r_sck;
   logic [31:0]      r_tx;
   logic [31:0]      r_rx;

   logic             w_accept;
   logic             w_tc;
   logic             w_last_fall;
   logic             w_cs_active;
   logic [1:0]       w_mode_in;
   logic [5:0]       w_half_init;

   assign w_accept    = cmd_valid_i && (r_state == ST_IDLE);
   assign w_tc        = (r_div_cnt == '0);
   assign w_last_fall = r_sck && (r_half_cnt == 6'd0);
   assign w_cs_active = (r_state == ST_CS_SETUP) || (r_state == ST_SHIFT) ||
                        (r_state == ST_CS_HOLD);
   assign w_mode_in   = (cmd_mode_i == 2'b11) ? MODE_STD : cmd_mode_i;

   // Remaining sck toggles after the first one: 2*cycles-1, so it reaches 0 on the last fall
   assign w_half_init = (w_mode_in == MODE_STD) ? {cmd_len_i, 1'b1}
                                                : {2'b00, cmd_len_i[4:2], 1'b1};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:     if (w_accept) w_next = ST_CS_SETUP;
         ST_CS_SETUP: if (w_tc) w_next = ST_SHIFT;
         ST_SHIFT:    if (w_tc && w_last_fall) w_next = ST_CS_HOLD;
         ST_CS_HOLD:  if (w_tc) w_next = (r_mode == MODE_QTX) ? ST_IDLE : ST_RX_WAIT;
         ST_RX_WAIT:  if (rx_ready_i) w_next = ST_IDLE;
         default:     w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mode     <= MODE_STD;
         r_div      <= '0;
         r_div_cnt  <= '0;
         r_half_cnt <= '0;
         r_sck      <= 1'b0;
         r_tx       <= '0;
         r_rx       <= '0;
      end else if (w_accept) begin
         r_mode     <= w_mode_in;
         r_div      <= cmd_div_i;
         r_div_cnt  <= cmd_div_i;
         r_half_cnt <= w_half_init;
         r_sck      <= 1'b0;
         r_tx       <= cmd_txdata_i;
         r_rx       <= '0;
      end else if (w_cs_active) begin
         if (w_tc) begin
            r_div_cnt <= r_div;
         end else begin
            r_div_cnt <= r_div_cnt - 1'b1;
         end
         if ((r_state == ST_SHIFT) && w_tc) begin
            r_sck <= ~r_sck;
            if (r_half_cnt != 6'd0) begin
               r_half_cnt <= r_half_cnt - 6'd1;
            end
            if (!r_sck) begin
               if (r_mode == MODE_STD) begin
                  r_rx <= {r_rx[30:0], spi_sdi0_i};
               end else if (r_mode == MODE_QRX) begin
                  r_rx <= {r_rx[27:0], spi_sdi3_i, spi_sdi2_i, spi_sdi1_i, spi_sdi0_i};
               end
            end else if (!w_last_fall) begin
               r_tx <= (r_mode == MODE_STD) ? {r_tx[30:0], 1'b0} : {r_tx[27:0], 4'h0};
            end
         end
      end
   end

   always_comb begin
      cmd_ready_o = (r_state == ST_IDLE);
      busy_o      = (r_state != ST_IDLE);
      rx_valid_o  = (r_state == ST_RX_WAIT);
      rx_data_o   = (r_state == ST_RX_WAIT) ? r_rx : 32'h0;
      padmode_o   = (r_state == ST_IDLE) ? MODE_STD : r_mode;
      spi_csn_o   = !w_cs_active;
      spi_sck_o   = r_sck;
      spi_sdo0_o  = 1'b0;
      spi_sdo1_o  = 1'b0;
      spi_sdo2_o  = 1'b0;
      spi_sdo3_o  = 1'b0;
      if (w_cs_active) begin
         if (r_mode == MODE_STD) begin
            spi_sdo0_o = r_tx[31];
         end else if (r_mode == MODE_QTX) begin
            {spi_sdo3_o, spi_sdo2_o, spi_sdo1_o, spi_sdo0_o} = r_tx[31:28];
         end
      end
   end

endmodule

// File: tb/tb_spi_master_engine.sv
// Scoreboard bench for spi_master_engine: driver queues expected transfers, monitors
// on the pins check waveform timing, transmitted bits and received words.
module tb_spi_master_engine;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [1:0]  cmd_mode_i = 2'b00;
   logic [4:0]  cmd_len_i = 5'd0;
   logic [31:0] cmd_txdata_i = 32'h0;
   logic [7:0]  cmd_div_i = 8'd0;
   logic        rx_valid_o;
   logic        rx_ready_i = 1'b1;
   logic [31:0] rx_data_o;
   logic        busy_o;
   logic [1:0]  padmode_o;
   logic        spi_csn_o, spi_sck_o;
   logic        spi_sdo0_o, spi_sdo1_o, spi_sdo2_o, spi_sdo3_o;
   logic        spi_sdi0_i, spi_sdi1_i, spi_sdi2_i, spi_sdi3_i;

   logic        lb = 1'b0;
   logic [3:0]  sdi_drv = 4'h0;
   logic        rdy_force = 1'b0;
   logic        rdy_val = 1'b1;

   assign spi_sdi0_i = lb ? spi_sdo0_o : sdi_drv[0];
   assign spi_sdi1_i = sdi_drv[1];
   assign spi_sdi2_i = sdi_drv[2];
   assign spi_sdi3_i = sdi_drv[3];

   spi_master_engine #(.DIV_W(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_mode_i(cmd_mode_i), .cmd_len_i(cmd_len_i),
      .cmd_txdata_i(cmd_txdata_i), .cmd_div_i(cmd_div_i),
      .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
      .busy_o(busy_o), .padmode_o(padmode_o),
      .spi_csn_o(spi_csn_o), .spi_sck_o(spi_sck_o),
      .spi_sdo0_o(spi_sdo0_o), .spi_sdo1_o(spi_sdo1_o),
      .spi_sdo2_o(spi_sdo2_o), .spi_sdo3_o(spi_sdo3_o),
      .spi_sdi0_i(spi_sdi0_i), .spi_sdi1_i(spi_sdi1_i),
      .spi_sdi2_i(spi_sdi2_i), .spi_sdi3_i(spi_sdi3_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0]  mode;
      int          n;
      int          div;
      logic [31:0] tx;
      logic [31:0] rxw;
   } txn_t;

   txn_t        txq[$];
   logic [31:0] rxq[$];
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rx(input txn_t t);
      int          nb;
      logic [63:0] m;
      nb = (t.mode == 2'b00) ? t.n : 4 * t.n;
      m  = (64'd1 << nb) - 64'd1;
      return t.rxw & m[31:0];
   endfunction

   function automatic logic [31:0] exp_sdo(input txn_t t, input int k);
      if (t.mode == 2'b00) return (t.tx >> (31 - k)) & 32'h1;
      if (t.mode == 2'b01) return (t.tx >> (28 - 4 * k)) & 32'hF;
      return 32'h0;
   endfunction

   function automatic logic [3:0] sdi_val(input txn_t t, input int k);
      logic [31:0] v;
      v = 32'h0;
      if (k < t.n) begin
         if (t.mode == 2'b00) v = (t.rxw >> (t.n - 1 - k)) & 32'h1;
         else if (t.mode == 2'b10) v = (t.rxw >> (4 * (t.n - 1 - k))) & 32'hF;
      end
      return v[3:0];
   endfunction

   // Pin monitor: csn-low duration, sck rise count and data on each rising sck
   txn_t cur;
   bit   active = 0;
   int   lowcnt = 0;
   int   k = 0;
   logic prev_sck = 1'b0;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         active = 0;
         prev_sck = 1'b0;
      end else begin
         if (!spi_csn_o) begin
            if (!active) begin
               if (txq.size() == 0) begin
                  chk("unexpected_csn_low", {31'h0, spi_csn_o}, 32'h1);
                  cur = '{2'b00, 0, 0, 32'h0, 32'h0};
               end else begin
                  cur = txq.pop_front();
                  chk("padmode", {30'h0, padmode_o}, {30'h0, cur.mode});
               end
               active = 1;
               lowcnt = 0;
               k = 0;
               sdi_drv <= sdi_val(cur, 0);
            end
            lowcnt++;
            if (spi_sck_o && !prev_sck) begin
               if (k < cur.n)
                  chk("sdo_at_rise", {28'h0, spi_sdo3_o, spi_sdo2_o, spi_sdo1_o, spi_sdo0_o},
                      exp_sdo(cur, k));
               else
                  chk("extra_sck_rise", k, cur.n);
               k++;
               sdi_drv <= sdi_val(cur, k);
            end
         end else if (active) begin
            chk("csn_low_cycles", lowcnt, (cur.div + 1) * (2 * cur.n + 2));
            chk("sck_rises", k, cur.n);
            chk("sck_idle_low", {31'h0, spi_sck_o}, 32'h0);
            active = 0;
         end
         prev_sck = spi_sck_o;
      end
   end

   // Receive monitor: every RX_WAIT cycle is compared, the word retires on handshake
   always @(negedge clk_i) begin
      if (rst_ni && rx_valid_o) begin
         if (rxq.size() == 0) begin
            chk("unexpected_rx_valid", {31'h0, rx_valid_o}, 32'h0);
         end else begin
            chk("rx_data", rx_data_o, rxq[0]);
            chk("cmd_ready_in_rx_wait", {31'h0, cmd_ready_o}, 32'h0);
            if (rx_ready_i) void'(rxq.pop_front());
         end
      end
   end

   always @(posedge clk_i) begin
      rx_ready_i <= rdy_force ? rdy_val : ($urandom_range(0, 2) != 0);
   end

   task automatic send(input logic [1:0] mode, input logic [4:0] len, input logic [31:0] tx,
                       input logic [7:0] div, input logic [31:0] rxw);
      txn_t       t;
      logic [1:0] em;
      int         n;
      int         w;
      em = (mode == 2'b11) ? 2'b00 : mode;
      n  = (em == 2'b00) ? int'(len) + 1 : int'(len[4:2]) + 1;
      t  = '{em, n, int'(div), tx, rxw};
      w  = 0;
      @(negedge clk_i);
      cmd_mode_i   = mode;
      cmd_len_i    = len;
      cmd_txdata_i = tx;
      cmd_div_i    = div;
      cmd_valid_i  = 1'b1;
      while (!cmd_ready_o) begin
         w++;
         if (w > 3000) begin
            chk("accept_timeout", {31'h0, cmd_ready_o}, 32'h1);
            cmd_valid_i = 1'b0;
            return;
         end
         @(negedge clk_i);
      end
      txq.push_back(t);
      if (em != 2'b01) rxq.push_back(exp_rx(t));
      @(posedge clk_i);
      #1 cmd_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      @(negedge clk_i);
      while (busy_o || txq.size() != 0 || rxq.size() != 0) begin
         w++;
         if (w > 5000) begin
            chk("idle_timeout", {31'h0, busy_o}, 32'h0);
            return;
         end
         @(negedge clk_i);
      end
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_csn"}, {31'h0, spi_csn_o}, 32'h1);
      chk({tag, "_sck"}, {31'h0, spi_sck_o}, 32'h0);
      chk({tag, "_padmode"}, {30'h0, padmode_o}, 32'h0);
      chk({tag, "_cmd_ready"}, {31'h0, cmd_ready_o}, 32'h1);
      chk({tag, "_rx_valid"}, {31'h0, rx_valid_o}, 32'h0);
      chk({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
      chk({tag, "_sdo"}, {28'h0, spi_sdo3_o, spi_sdo2_o, spi_sdo1_o, spi_sdo0_o}, 32'h0);
      chk({tag, "_rx_data"}, rx_data_o, 32'h0);
   endtask

   initial begin
      logic [31:0] r1;
      logic [31:0] r2;
      int          w;

      #3 check_quiet("reset");
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);

      lb = 1'b1;
      send(2'b00, 5'd7, 32'hA500_0000, 8'd0, 32'h0000_00A5);
      wait_idle();
      lb = 1'b0;

      send(2'b01, 5'd31, 32'h1234_5678, 8'd1, 32'h0);
      wait_idle();

      send(2'b10, 5'd7, 32'hFFFF_FFFF, 8'd2, 32'h0000_00C3);
      wait_idle();

      // Stalled receiver with a competing command request
      rdy_force = 1'b1;
      rdy_val   = 1'b0;
      send(2'b00, 5'd15, $urandom, 8'd1, $urandom);
      w = 0;
      while (!rx_valid_o && w < 2000) begin
         @(negedge clk_i);
         w++;
      end
      chk("rx_valid_reached", {31'h0, rx_valid_o}, 32'h1);
      cmd_mode_i  = 2'b01;
      cmd_valid_i = 1'b1;
      repeat (5) begin
         @(negedge clk_i);
         chk("stall_cmd_ready", {31'h0, cmd_ready_o}, 32'h0);
         chk("stall_rx_valid", {31'h0, rx_valid_o}, 32'h1);
      end
      cmd_valid_i = 1'b0;
      rdy_force   = 1'b0;
      wait_idle();

      // Boundary lengths and random traffic
      send(2'b00, 5'd31, $urandom, 8'd0, $urandom);
      send(2'b00, 5'd0, $urandom, 8'd0, $urandom);
      send(2'b10, 5'd31, $urandom, 8'd0, $urandom);
      send(2'b01, 5'd0, $urandom, 8'd3, $urandom);
      for (int i = 0; i < 30; i++) begin
         r1 = $urandom;
         r2 = $urandom;
         send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), r1,
              8'($urandom_range(0, 3)), r2);
      end
      wait_idle();

      // Reset in the middle of a shift
      send(2'b00, 5'd31, $urandom, 8'd3, $urandom);
      w = 0;
      @(negedge clk_i);
      while (!spi_sck_o && w < 500) begin
         @(negedge clk_i);
         w++;
      end
      chk("sck_high_before_reset", {31'h0, spi_sck_o}, 32'h1);
      #2 rst_ni = 1'b0;
      #1 check_quiet("midreset");
      rxq.delete();
      txq.delete();
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (100) @(negedge clk_i);
      chk("post_reset_rx_valid", {31'h0, rx_valid_o}, 32'h0);
      chk("post_reset_busy", {31'h0, busy_o}, 32'h0);

      send(2'b10, 5'd15, 32'h0, 8'd1, $urandom);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
